pool1_maxpool_write: RTL and testbench

2x2 max-pooling and write stage directly downstream of the conv1 output-memory read addresser. Each cycle the addresser issues a 2x2 window, the conv1 memory returns four words `rd_data0..3`. This block takes the signed maximum of the four words and optionally applies ReLU. It writes the result sequentially into the pool1 output memory and signals `done` once the last pooled value is written.

---
 rtl/pool1_maxpool_write.sv | 123 ++++++++++++
 tb/tb_pool1_maxpool_write.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_maxpool_write.sv
// 2x2 signed max-pool with optional ReLU, writing pooled values sequentially
// into the pool1 memory behind a conv1 read addresser.
module pool1_maxpool_write #(
  parameter int DATA_W  = 16,
  parameter int NUM_OUT = 144,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int RELU_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] rd_data3,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // Counter must reach NUM_OUT itself, which may not fit in ADDR_W bits.
  localparam int CW0   = $clog2(NUM_OUT + 1);
  localparam int CNT_W = (CW0 > ADDR_W) ? CW0 : ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                   state;
  logic [RD_LAT-1:0]        vld;
  logic                     s1_v;
  logic                     s2_v;
  logic signed [DATA_W-1:0] m01;
  logic signed [DATA_W-1:0] m23;
  logic [CNT_W-1:0]         wcnt;

  logic                     issue;
  logic                     dv;
  logic                     full;
  logic                     pipe_empty;
  logic signed [DATA_W-1:0] d0, d1, d2, d3;
  logic signed [DATA_W-1:0] m;
  logic signed [DATA_W-1:0] mo;

  assign d0 = rd_data0;
  assign d1 = rd_data1;
  assign d2 = rd_data2;
  assign d3 = rd_data3;

  assign issue      = enable & ~rd_done & (state != FIN);
  assign dv         = vld[RD_LAT-1];
  assign full       = (wcnt == CNT_W'(NUM_OUT));
  assign pipe_empty = ~(|vld) & ~s1_v & ~s2_v;
  assign state_dbg  = state;

  always_comb begin
    m  = (m01 >= m23) ? m01 : m23;
    mo = m;
    if (RELU_EN != 0 && m[DATA_W-1]) mo = '0;
  end

  // wr_en is a one-cycle strobe per pooled value; there is no backpressure,
  // so wr_addr/wr_data are valid exactly in cycles where wr_en is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      vld     <= '0;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      m01     <= '0;
      m23     <= '0;
      wcnt    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      if (state == FIN) begin
        vld   <= '0;
        s1_v  <= 1'b0;
        s2_v  <= 1'b0;
        wr_en <= 1'b0;
      end else begin
        vld  <= (vld << 1) | RD_LAT'(issue);
        s1_v <= dv;
        if (dv) begin
          m01 <= (d0 >= d1) ? d0 : d1;
          m23 <= (d2 >= d3) ? d2 : d3;
        end
        s2_v  <= s1_v;
        wr_en <= s1_v & ~full;
        if (s1_v) wr_data <= mo;
        // Results arriving after the map is complete are dropped silently.
        if (s1_v && !full) begin
          wr_addr <= wcnt[ADDR_W-1:0];
          wcnt    <= wcnt + CNT_W'(1);
        end
      end

      case (state)
        IDLE: if (issue) state <= RUN;
        RUN: begin
          if (full) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (rd_done) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (full || pipe_empty) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        default: state <= FIN;
      endcase
    end
  end

endmodule

// File: tb/tb_pool1_maxpool_write.sv
// Bench for pool1_maxpool_write: table vectors plus directed multi-cycle
// sequences on three instances (ReLU, no ReLU, 3-cycle read latency).
module tb_pool1_maxpool_write;

  localparam int N = 144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en_ab, rdd_ab, en_c, rdd_c;
  logic [63:0] win_ab, win_c;
  logic [63:0] mem_ab, mem_c0, mem_c1, mem_c2;

  logic        wr_en_a, wr_en_b, wr_en_c;
  logic [7:0]  wr_addr_a, wr_addr_b, wr_addr_c;
  logic [15:0] wr_data_a, wr_data_b, wr_data_c;
  logic        done_a, done_b, done_c;
  logic [1:0]  st_a, st_b, st_c;

  // conv1 memory model: the window addressed in a cycle appears RD_LAT later
  always @(posedge clk) begin
    mem_ab <= win_ab;
    mem_c0 <= win_c;
    mem_c1 <= mem_c0;
    mem_c2 <= mem_c1;
  end

  pool1_maxpool_write #(.RD_LAT(1), .RELU_EN(1)) u_a (
    .clk(clk), .reset(reset), .enable(en_ab), .rd_done(rdd_ab),
    .rd_data0(mem_ab[63:48]), .rd_data1(mem_ab[47:32]),
    .rd_data2(mem_ab[31:16]), .rd_data3(mem_ab[15:0]),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .done(done_a), .state_dbg(st_a));

  pool1_maxpool_write #(.RD_LAT(1), .RELU_EN(0)) u_b (
    .clk(clk), .reset(reset), .enable(en_ab), .rd_done(rdd_ab),
    .rd_data0(mem_ab[63:48]), .rd_data1(mem_ab[47:32]),
    .rd_data2(mem_ab[31:16]), .rd_data3(mem_ab[15:0]),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .done(done_b), .state_dbg(st_b));

  pool1_maxpool_write #(.RD_LAT(3), .RELU_EN(1)) u_c (
    .clk(clk), .reset(reset), .enable(en_c), .rd_done(rdd_c),
    .rd_data0(mem_c2[63:48]), .rd_data1(mem_c2[47:32]),
    .rd_data2(mem_c2[31:16]), .rd_data3(mem_c2[15:0]),
    .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .done(done_c), .state_dbg(st_c));

  int n_checks;
  int n_fail;
  int cyc;
  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  logic [23:0] exp_c[$];
  int iss_ab, iss_c;
  int wcnt_a, wcnt_b, wcnt_c;
  int first_a, first_c;
  int done_cyc_a;
  int wcyc_a[256];

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: write seen with no expected entry", name);
  endtask

  // Scoreboard monitors, sampling on the falling edge
  initial forever begin
    logic [23:0] e;
    @(negedge clk);
    if (reset) begin
      wcnt_a = 0; first_a = -1; done_cyc_a = -1;
    end else begin
      if (wr_en_a) begin
        if (wcnt_a == 0) first_a = cyc;
        if (wcnt_a < 256) wcyc_a[wcnt_a] = cyc;
        if (exp_a.size() == 0) unexpected("a_write");
        else begin
          e = exp_a.pop_front();
          check("a_wr_addr", 32'(wr_addr_a), 32'(e[23:16]));
          check("a_wr_data", 32'(wr_data_a), 32'(e[15:0]));
        end
        wcnt_a++;
      end
      if (done_a && done_cyc_a < 0) done_cyc_a = cyc;
    end
  end

  initial forever begin
    logic [23:0] e;
    @(negedge clk);
    if (reset) wcnt_b = 0;
    else if (wr_en_b) begin
      if (exp_b.size() == 0) unexpected("b_write");
      else begin
        e = exp_b.pop_front();
        check("b_wr_addr", 32'(wr_addr_b), 32'(e[23:16]));
        check("b_wr_data", 32'(wr_data_b), 32'(e[15:0]));
      end
      wcnt_b++;
    end
  end

  initial forever begin
    logic [23:0] e;
    @(negedge clk);
    if (reset) begin
      wcnt_c = 0; first_c = -1;
    end else if (wr_en_c) begin
      if (wcnt_c == 0) first_c = cyc;
      if (exp_c.size() == 0) unexpected("c_write");
      else begin
        e = exp_c.pop_front();
        check("c_wr_addr", 32'(wr_addr_c), 32'(e[23:16]));
        check("c_wr_data", 32'(wr_data_c), 32'(e[15:0]));
      end
      wcnt_c++;
    end
  end

  task automatic drive_ab(input logic en, input logic rdd, input logic [63:0] w,
                          input logic [15:0] ea, input logic [15:0] eb);
    en_ab = en; rdd_ab = rdd; win_ab = w;
    @(posedge clk); #1;
    if (en && !rdd && iss_ab < N) begin
      exp_a.push_back({8'(iss_ab), ea});
      exp_b.push_back({8'(iss_ab), eb});
      iss_ab++;
    end
  endtask

  task automatic drive_c(input logic en, input logic rdd, input logic [63:0] w,
                         input logic [15:0] ec);
    en_c = en; rdd_c = rdd; win_c = w;
    @(posedge clk); #1;
    if (en && !rdd && iss_c < N) begin
      exp_c.push_back({8'(iss_c), ec});
      iss_c++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en_ab = 1'b0; rdd_ab = 1'b0; en_c = 1'b0; rdd_c = 1'b0;
    exp_a.delete(); exp_b.delete(); exp_c.delete();
    iss_ab = 0; iss_c = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done(input bit is_c, input string name);
    int k;
    k = 0;
    while (k < 60 && !(is_c ? done_c : (done_a && done_b))) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    if (is_c) check({name, "_done_c"}, 32'(done_c), 32'd1);
    else begin
      check({name, "_done_a"}, 32'(done_a), 32'd1);
      check({name, "_done_b"}, 32'(done_b), 32'd1);
    end
  endtask

  typedef struct {
    logic [63:0] win;
    logic [15:0] exp_relu;
    logic [15:0] exp_raw;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    en_ab = 1'b0; rdd_ab = 1'b0; en_c = 1'b0; rdd_c = 1'b0;
    win_ab = '0; win_c = '0;
    iss_ab = 0; iss_c = 0;

    vt[0]  = '{64'h0064_0000_0000_0000, 16'h0064, 16'h0064};
    vt[1]  = '{64'h0000_0064_0000_0000, 16'h0064, 16'h0064};
    vt[2]  = '{64'h0000_0000_0064_0000, 16'h0064, 16'h0064};
    vt[3]  = '{64'h0000_0000_0000_0064, 16'h0064, 16'h0064};
    vt[4]  = '{64'hFFFB_FFFD_FFF7_FFFF, 16'h0000, 16'hFFFF};
    vt[5]  = '{64'h7FFF_8000_0005_0005, 16'h7FFF, 16'h7FFF};
    vt[6]  = '{64'h8000_8000_8000_8000, 16'h0000, 16'h8000};
    vt[7]  = '{64'h0003_0003_0003_0003, 16'h0003, 16'h0003};
    vt[8]  = '{64'hFFFE_0000_FFF9_FFFF, 16'h0000, 16'h0000};
    vt[9]  = '{64'h1234_7FFE_7FFF_0001, 16'h7FFF, 16'h7FFF};
    vt[10] = '{64'hFFFE_FFFD_8001_FFFF, 16'h0000, 16'hFFFF};
    vt[11] = '{64'h000A_0014_001E_FFD8, 16'h001E, 16'h001E};

    // Reset values appear before any clock edge
    #1;
    check("rst_async_wr_en", 32'(wr_en_a), 32'd0);
    check("rst_async_done", 32'(done_a), 32'd0);
    do_reset();
    check("rst_wr_en", 32'(wr_en_a), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_a), 32'd0);
    check("rst_wr_data", 32'(wr_data_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_done_c", 32'(done_c), 32'd0);

    // Table vectors: max position, signed extremes, ReLU on/off
    p0 = 0;
    for (int i = 0; i < 12; i++) begin
      drive_ab(1'b1, 1'b0, vt[i].win, vt[i].exp_relu, vt[i].exp_raw);
      if (i == 0) p0 = cyc;
    end
    drive_ab(1'b1, 1'b1, '0, '0, '0);
    wait_done(1'b0, "tbl");
    check("tbl_latency", 32'(first_a - p0 + 1), 32'd3);
    check("tbl_writes_a", 32'(wcnt_a), 32'd12);
    check("tbl_writes_b", 32'(wcnt_b), 32'd12);
    check("tbl_left_a", 32'(exp_a.size()), 32'd0);

    // Full map of 144 windows (1,2,3,4)
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive_ab(1'b1, 1'b0, 64'h0001_0002_0003_0004, 16'd4, 16'd4);
      if (i == 0) p0 = cyc;
    end
    drive_ab(1'b0, 1'b0, '0, '0, '0);
    wait_done(1'b0, "full");
    check("full_latency", 32'(first_a - p0 + 1), 32'd3);
    check("full_writes", 32'(wcnt_a), 32'd144);
    check("full_done_timing", 32'(done_cyc_a), 32'(wcyc_a[143] + 1));
    check("full_left_a", 32'(exp_a.size()), 32'd0);

    // Pause for 5 cycles after issue 10
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [15:0] e;
      if (i == 10) repeat (5) drive_ab(1'b0, 1'b0, '0, '0, '0);
      e = (i == 0) ? 16'd1 : 16'(2 * i);
      drive_ab(1'b1, 1'b0, {16'(i), 16'(i + 1), 16'(-i), 16'(2 * i)}, e, e);
    end
    drive_ab(1'b1, 1'b1, '0, '0, '0);
    wait_done(1'b0, "pause");
    check("pause_writes", 32'(wcnt_a), 32'd20);
    check("pause_burst_span", 32'(wcyc_a[9] - wcyc_a[0]), 32'd9);
    check("pause_gap", 32'(wcyc_a[10] - wcyc_a[9]), 32'd6);
    check("pause_left_a", 32'(exp_a.size()), 32'd0);

    // Overrun: 150 issues, only 144 written, done sticky afterwards
    do_reset();
    for (int i = 0; i < 150; i++)
      drive_ab(1'b1, 1'b0, {16'(i), 16'd0, 16'd0, 16'd0}, 16'(i), 16'(i));
    drive_ab(1'b0, 1'b0, '0, '0, '0);
    wait_done(1'b0, "ovr");
    check("ovr_writes", 32'(wcnt_a), 32'd144);
    repeat (5) drive_ab(1'b1, 1'b0, 64'h0001_0001_0001_0001, 16'd1, 16'd1);
    repeat (4) drive_ab(1'b0, 1'b0, '0, '0, '0);
    check("ovr_no_more_writes", 32'(wcnt_a), 32'd144);
    check("ovr_done_sticky", 32'(done_a), 32'd1);
    check("ovr_left_a", 32'(exp_a.size()), 32'd0);

    // Early stop after 50 issues
    do_reset();
    for (int i = 0; i < 50; i++)
      drive_ab(1'b1, 1'b0, {16'd0, 16'(i + 3), 16'd0, 16'd0}, 16'(i + 3), 16'(i + 3));
    drive_ab(1'b1, 1'b1, '0, '0, '0);
    wait_done(1'b0, "early");
    check("early_writes_a", 32'(wcnt_a), 32'd50);
    check("early_writes_b", 32'(wcnt_b), 32'd50);
    check("early_left_a", 32'(exp_a.size()), 32'd0);

    // RD_LAT=3: asynchronous reset at write 70, then a fresh run
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive_c(1'b1, 1'b0, {16'(i), 16'(i), 16'(i), 16'(i)}, 16'(i));
      if (wcnt_c >= 70) break;
    end
    #1 reset = 1'b1;
    en_c = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en_c), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr_c), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data_c), 32'd0);
    check("mid_rst_done", 32'(done_c), 32'd0);
    exp_c.delete();
    iss_c = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    p0 = 0;
    for (int i = 0; i < 12; i++) begin
      drive_c(1'b1, 1'b0, {16'd0, 16'd0, 16'd0, 16'(i + 7)}, 16'(i + 7));
      if (i == 0) p0 = cyc;
    end
    drive_c(1'b1, 1'b1, '0, '0);
    wait_done(1'b1, "restart");
    check("restart_latency", 32'(first_c - p0 + 1), 32'd5);
    check("restart_writes", 32'(wcnt_c), 32'd12);
    check("restart_left_c", 32'(exp_c.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
